// File: rtl/am2910_pkg.sv
// Shared definitions for the am2910 microprogram sequencer: opcodes,
// enable-select encoding and default sizes.
package am2910_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int DEPTH_DEF = 5;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    SEL_PL   = 2'd0,
    SEL_MAP  = 2'd1,
    SEL_VECT = 2'd2
  } en_sel_t;

  // Returns {nVECT, nMAP, nPL}; exactly one bit is low for any select.
  function automatic logic [2:0] en_decode(input en_sel_t sel);
    case (sel)
      SEL_MAP:  en_decode = 3'b101;
      SEL_VECT: en_decode = 3'b011;
      default:  en_decode = 3'b110;
    endcase
  endfunction

endpackage

// File: rtl/am2910_stack.sv
// LIFO for subroutine/loop return addresses with a saturating pointer:
// push while full overwrites the last entry, pop while empty holds at zero.
module am2910_stack
  import am2910_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SP_W-1:0]  rd_idx;

  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  // An empty stack still presents entry 0 as its top.
  assign rd_idx = empty ? '0 : sp_q - SP_W'(1);
  assign top    = mem_q[rd_idx];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      if (full) begin
        mem_d[DEPTH-1] = din;
      end else begin
        mem_d[sp_q] = din;
        sp_d        = sp_q + SP_W'(1);
      end
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/am2910.sv
// Am2910 microprogram sequencer: next-address select, uPC, R counter, stack.
// Optional sticky stack-error flag and port with AM2910_STACK_ERR_EN.
module am2910
  import am2910_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] D,
  input  logic             nCC,
  input  logic             nCCEN,
  input  logic             CI,
  input  logic             nRLD,
  input  logic             nOE,
  output logic [WIDTH-1:0] Y,
  output logic             nFULL,
  output logic             nPL,
  output logic             nMAP,
`ifdef AM2910_STACK_ERR_EN
  output logic             stk_err,
`endif
  output logic             nVECT
);

  logic [WIDTH-1:0] upc_q, upc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] y_int;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;
  logic             push, pop_req, clear, r_load, r_dec;
  logic             pass, r_nz;
  en_sel_t          en_sel;
  opcode_t          op;

  assign op   = opcode_t'(I);
  assign pass = nCCEN | ~nCC;
  assign r_nz = (r_q != '0);

  always_comb begin
    y_int   = upc_q;
    push    = 1'b0;
    pop_req = 1'b0;
    clear   = 1'b0;
    r_load  = 1'b0;
    r_dec   = 1'b0;
    en_sel  = SEL_PL;
    case (op)
      JZ:   begin y_int = '0; clear = 1'b1; end
      CJS:  begin if (pass) y_int = D; push = pass; end
      JMAP: begin y_int = D; en_sel = SEL_MAP; end
      CJP:  if (pass) y_int = D;
      PUSH: begin push = 1'b1; r_load = pass; end
      JSRP: begin y_int = pass ? D : r_q; push = 1'b1; end
      CJV:  begin if (pass) y_int = D; en_sel = SEL_VECT; end
      JRP:  y_int = pass ? D : r_q;
      RFCT: if (r_nz) begin y_int = stk_top; r_dec = 1'b1; end
            else pop_req = 1'b1;
      RPCT: if (r_nz) begin y_int = D; r_dec = 1'b1; end
      CRTN: begin if (pass) y_int = stk_top; pop_req = pass; end
      CJPP: begin if (pass) y_int = D; pop_req = pass; end
      LDCT: r_load = 1'b1;
      LOOP: begin if (!pass) y_int = stk_top; pop_req = pass; end
      CONT: y_int = upc_q;
      TWB:  if (pass) pop_req = 1'b1;
            else if (r_nz) begin y_int = stk_top; r_dec = 1'b1; end
            else begin y_int = D; pop_req = 1'b1; end
      default: y_int = upc_q;
    endcase
  end

  // nRLD load wins over any decrement in the same cycle.
  always_comb begin
    upc_d = y_int + WIDTH'(CI);
    r_d   = r_q;
    if (!nRLD || r_load) r_d = D;
    else if (r_dec)      r_d = r_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  am2910_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst_n(nRST),
    .push (push),
    .pop  (pop_req & ~stk_empty),
    .clear(clear),
    .din  (upc_q),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

`ifdef AM2910_STACK_ERR_EN
  logic stk_err_q, stk_err_d;

  always_comb begin
    stk_err_d = stk_err_q;
    if (op == JZ)
      stk_err_d = 1'b0;
    else if ((push && stk_full) || (pop_req && stk_empty))
      stk_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) stk_err_q <= 1'b0;
    else       stk_err_q <= stk_err_d;
  end

  assign stk_err = stk_err_q;
`endif

  assign {nVECT, nMAP, nPL} = en_decode(en_sel);
  assign nFULL = ~stk_full;
  assign Y     = nOE ? {WIDTH{1'bz}} : y_int;

endmodule

// File: tb/tb_am2910.sv
// Directed testbench for am2910 (WIDTH=12, DEPTH=5).
module tb_am2910;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  I;
  logic [11:0] D;
  logic        nCC, nCCEN, CI, nRLD, nOE;
  wire  [11:0] Y;
  logic        nFULL, nPL, nMAP, nVECT;
  logic        tb_drv;
`ifdef AM2910_STACK_ERR_EN
  logic        stk_err;
`endif

  int checks = 0;
  int errors = 0;

  // Bench-side driver on the Y bus; only wins when the DUT releases Y.
  assign Y = tb_drv ? 12'h000 : 12'hzzz;

  always #5 clk = ~clk;

  am2910 #(.WIDTH(12), .DEPTH(5)) dut (
    .clk  (clk),
    .nRST (nRST),
    .I    (I),
    .D    (D),
    .nCC  (nCC),
    .nCCEN(nCCEN),
    .CI   (CI),
    .nRLD (nRLD),
    .nOE  (nOE),
    .Y    (Y),
    .nFULL(nFULL),
    .nPL  (nPL),
    .nMAP (nMAP),
`ifdef AM2910_STACK_ERR_EN
    .stk_err(stk_err),
`endif
    .nVECT(nVECT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply one instruction, let combinational outputs settle.
  task automatic apply(input logic [3:0] op, input logic [11:0] d,
                       input logic ncc, input logic nccen);
    I = op; D = d; nCC = ncc; nCCEN = nccen;
    #1;
  endtask

  initial begin
    nRST = 1'b0; I = 4'd14; D = '0; nCC = 1'b1; nCCEN = 1'b1;
    CI = 1'b1; nRLD = 1'b1; nOE = 1'b0; tb_drv = 1'b0;
    #2;
    check("reset_y", Y, 12'h000);
    check("reset_nfull", nFULL, 1'b1);
    #1 nRST = 1'b1;

    // CONT sequence
    apply(4'd14, 12'h000, 1'b1, 1'b1);
    check("cont_y0", Y, 12'h000);
    check("cont_npl", {nVECT, nMAP, nPL}, 3'b110);
    tick; check("cont_y1", Y, 12'h001);
    tick; check("cont_y2", Y, 12'h002);
    tick; check("cont_y3", Y, 12'h003);
    check("cont_nfull", nFULL, 1'b1);

    // Jump to 0x010, CJS from there, CRTN back to 0x011
    tick;
    apply(4'd3, 12'h010, 1'b0, 1'b0);
    check("cjp_y", Y, 12'h010);
    tick;
    apply(4'd1, 12'h200, 1'b0, 1'b0);
    check("cjs_y", Y, 12'h200);
    tick;
    apply(4'd10, 12'h000, 1'b0, 1'b0);
    check("crtn_y", Y, 12'h011);
    tick;
    check("crtn_empty_top", Y, 12'h011);

    // LDCT / RPCT repeat
    apply(4'd12, 12'h003, 1'b1, 1'b1);
    check("ldct_y", Y, 12'h012);
    tick;
    apply(4'd9, 12'h050, 1'b1, 1'b1);
    check("rpct_y1", Y, 12'h050);
    tick; check("rpct_y2", Y, 12'h050);
    tick; check("rpct_y3", Y, 12'h050);
    tick; check("rpct_exit", Y, 12'h051);
    tick;

    // Six pushes into a five-deep stack
    apply(4'd4, 12'h000, 1'b1, 1'b1);
    check("push1_y", Y, 12'h052);
    tick; tick; tick; tick;
    check("push5_nfull_before", nFULL, 1'b1);
`ifdef AM2910_STACK_ERR_EN
    check("stkerr_clear", stk_err, 1'b0);
`endif
    tick;
    check("push5_nfull", nFULL, 1'b0);
    check("push6_y", Y, 12'h057);
    tick;
    check("push6_nfull", nFULL, 1'b0);
`ifdef AM2910_STACK_ERR_EN
    check("stkerr_set", stk_err, 1'b1);
`endif
    apply(4'd10, 12'h000, 1'b1, 1'b1);
    check("overwrite_top", Y, 12'h057);
    tick;
    check("pop_top", Y, 12'h055);
    check("pop_nfull", nFULL, 1'b1);
    tick;
    apply(4'd0, 12'hABC, 1'b1, 1'b1);
    check("jz_y", Y, 12'h000);
    tick;
`ifdef AM2910_STACK_ERR_EN
    check("stkerr_jz", stk_err, 1'b0);
`endif

    // JMAP and CJV enables
    apply(4'd2, 12'h123, 1'b1, 1'b1);
    check("jmap_y", Y, 12'h123);
    check("jmap_en", {nVECT, nMAP, nPL}, 3'b101);
    tick;
    apply(4'd6, 12'h0F0, 1'b1, 1'b0);
    check("cjv_y", Y, 12'h124);
    check("cjv_en", {nVECT, nMAP, nPL}, 3'b011);
    tick;

    // Output disable: bench driver must be the only source
    apply(4'd14, 12'h000, 1'b1, 1'b1);
    nOE = 1'b1; tb_drv = 1'b1;
    #1 check("noe_hiz", Y, 12'h000);
    tb_drv = 1'b0; nOE = 1'b0;
    #1 check("noe_back", Y, 12'h125);

    // Reset in the middle of a loop
    apply(4'd12, 12'h002, 1'b1, 1'b1);
    tick;
    apply(4'd4, 12'h002, 1'b1, 1'b1);
    check("loop_push_y", Y, 12'h126);
    tick;
    apply(4'd8, 12'h000, 1'b1, 1'b1);
    check("rfct_y", Y, 12'h126);
    tick;
    apply(4'd14, 12'h000, 1'b1, 1'b1);
    #2 nRST = 1'b0;
    #1 check("async_rst_y", Y, 12'h000);
    check("async_rst_nfull", nFULL, 1'b1);
    #1 nRST = 1'b1;
    apply(4'd10, 12'h000, 1'b1, 1'b1);
    check("rst_stack_cleared", Y, 12'h000);
    tick;

    // nRLD overrides decrement; JRP fail exposes R
    apply(4'd12, 12'h001, 1'b1, 1'b1);
    check("ldct2_y", Y, 12'h001);
    tick;
    nRLD = 1'b0;
    apply(4'd9, 12'h050, 1'b1, 1'b1);
    check("rpct_nrld_y", Y, 12'h050);
    tick;
    nRLD = 1'b1;
    apply(4'd7, 12'h777, 1'b1, 1'b0);
    check("jrp_r", Y, 12'h050);
    tick;

    // uPC wrap at the top of the address space
    apply(4'd3, 12'hFFF, 1'b0, 1'b0);
    check("wrap_jump", Y, 12'hFFF);
    tick;
    apply(4'd14, 12'h000, 1'b1, 1'b1);
    check("wrap_y", Y, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
